cart_bus_sequencer: RTL

- Host-side bus master that drives the Bandai 2003 cartridge mapper pins: clock, reset, ADDR, DQ, CEn, SSn, OEn and WEn.
- Performs the mapper unlock handshake and verifies the serial SO signature.
- After unlock, executes single register and memory bus cycles on request.
- Sits between the dumper/programmer command engine and the cartridge connector.

---
 rtl/cart_bus_pkg.sv | 50 +++++
 rtl/cart_bus_sequencer_clk_gen.sv | 39 +++
 rtl/cart_bus_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_bus_pkg.sv
// Shared definitions for the Bandai 2003 cartridge bus sequencer:
// op/state encodings, handshake address values and mapper register map.
package cart_bus_pkg;

    typedef enum logic [2:0] {
        OP_UNLOCK = 3'd0,
        OP_REG_WR = 3'd1,
        OP_REG_RD = 3'd2,
        OP_MEM_RD = 3'd3,
        OP_MEM_WR = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_URST,
        ST_UADDR,
        ST_USAMP,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam logic [7:0] ACK = 8'h5A;
    localparam logic [7:0] NAK = 8'hA5;
    localparam logic [7:0] NIH = 8'hFF;

    localparam logic [17:0] SO_SIGNATURE = 18'h05140;
    localparam int unsigned SO_BITS      = 18;

    localparam logic [7:0] REG_C0 = 8'hC0;
    localparam logic [7:0] REG_C1 = 8'hC1;
    localparam logic [7:0] REG_C2 = 8'hC2;
    localparam logic [7:0] REG_C3 = 8'hC3;
    localparam logic [7:0] REG_D0 = 8'hD0;
    localparam logic [7:0] REG_D1 = 8'hD1;
    localparam logic [7:0] REG_D2 = 8'hD2;
    localparam logic [7:0] REG_D3 = 8'hD3;
    localparam logic [7:0] REG_D4 = 8'hD4;
    localparam logic [7:0] REG_D5 = 8'hD5;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_MEM_RD) || (op == OP_MEM_WR);
    endfunction

    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_REG_WR) || (op == OP_MEM_WR);
    endfunction

endpackage

// File: rtl/cart_bus_sequencer_clk_gen.sv
// Free-running CART_CLK divider; rise/fall strobes are high in the CLK cycle
// whose closing edge toggles CART_CLK.
module cart_clk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RSTn,
    output logic cart_clk,
    output logic clk_rise,
    output logic clk_fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       cart_clk_q, cart_clk_d;
    logic       tick;

    always_comb begin
        tick       = (cnt_q == DIV_LAST);
        cnt_d      = tick ? 8'd0 : cnt_q + 8'd1;
        cart_clk_d = tick ? ~cart_clk_q : cart_clk_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q      <= 8'd0;
            cart_clk_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cart_clk_q <= cart_clk_d;
        end
    end

    assign cart_clk = cart_clk_q;
    assign clk_rise = tick & ~cart_clk_q;
    assign clk_fall = tick & cart_clk_q;

endmodule

// File: rtl/cart_bus_sequencer.sv
// Host-side bus master for the Bandai 2003 mapper: unlock handshake with SO
// signature check, then single register/memory bus cycles on request.
module cart_bus_sequencer
    import cart_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned T_SU    = 1,
    parameter int unsigned T_PW    = 3,
    parameter int unsigned T_HLD   = 1,
    parameter int unsigned RST_CYC = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       unlocked,
    output logic       CART_CLK,
    output logic       CART_RSTn,
    output logic [7:0] CART_ADDR,
    output logic [7:0] CART_DQ_O,
    output logic       CART_DQ_OE,
    input  logic [7:0] CART_DQ_I,
    output logic       CART_CEn,
    output logic       CART_SSn,
    output logic       CART_OEn,
    output logic       CART_WEn,
    input  logic       CART_SO
);

    localparam logic [7:0] SU_LAST  = 8'(T_SU - 1);
    localparam logic [7:0] PW_LAST  = 8'(T_PW - 1);
    localparam logic [7:0] HLD_LAST = 8'(T_HLD - 1);
    localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);
    localparam logic [4:0] BIT_LAST = 5'(SO_BITS - 1);

    logic clk_rise, clk_fall;

    cart_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .cart_clk (CART_CLK),
        .clk_rise (clk_rise),
        .clk_fall (clk_fall)
    );

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        cen_q, cen_d, ssn_q, ssn_d, oen_q, oen_d, wen_q, wen_d;
    logic        cart_rstn_q, cart_rstn_d;
    logic        unlocked_q, unlocked_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [17:0] so_q, so_d;
    logic [4:0]  bit_q, bit_d;
    logic        uidx_q, uidx_d;
    logic        armed_q, armed_d;
    logic        cmd_bad;

    // Illegal requests are answered straight from IDLE without touching the pins.
    always_comb begin
        cmd_bad = (cmd_op > 3'd4)
               || ((cmd_op != OP_UNLOCK) && !unlocked_q)
               || (is_mem_op(cmd_op) && (cmd_addr[7:4] == 4'h0));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        cen_d       = cen_q;
        ssn_d       = ssn_q;
        oen_d       = oen_q;
        wen_d       = wen_q;
        cart_rstn_d = cart_rstn_q;
        unlocked_d  = unlocked_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        so_d        = so_q;
        bit_d       = bit_q;
        uidx_d      = uidx_q;
        armed_d     = armed_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cmd_op == OP_UNLOCK) begin
                        unlocked_d  = 1'b0;
                        cart_rstn_d = 1'b0;
                        cnt_d       = 8'd0;
                        state_d     = ST_URST;
                    end else begin
                        op_d   = cmd_op;
                        addr_d = cmd_addr;
                        cen_d  = ~is_mem_op(cmd_op);
                        ssn_d  = is_mem_op(cmd_op);
                        if (is_write_op(cmd_op)) begin
                            dq_oe_d = 1'b1;
                            dq_o_d  = cmd_wdata;
                        end
                        cnt_d   = 8'd0;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_URST: begin
                if (cnt_q == RST_LAST) begin
                    cart_rstn_d = 1'b1;
                    uidx_d      = 1'b0;
                    state_d     = ST_UADDR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_UADDR: begin
                if (clk_fall) begin
                    if (!uidx_q) begin
                        addr_d = ACK;
                        uidx_d = 1'b1;
                    end else begin
                        addr_d  = NAK;
                        bit_d   = 5'd0;
                        armed_d = 1'b0;
                        state_d = ST_USAMP;
                    end
                end
            end
            // SO sampling begins only after the mapper has seen NAK on a rising edge.
            ST_USAMP: begin
                if (clk_rise) begin
                    armed_d = 1'b1;
                end
                if (clk_fall && armed_q) begin
                    if (bit_q == 5'd0) begin
                        addr_d = NIH;
                    end
                    so_d = {CART_SO, so_q[17:1]};
                    if (bit_q == BIT_LAST) begin
                        unlocked_d = (so_d == SO_SIGNATURE);
                        err_d      = (so_d != SO_SIGNATURE);
                        state_d    = ST_DONE;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == SU_LAST) begin
                    oen_d   = is_write_op(op_q);
                    wen_d   = ~is_write_op(op_q);
                    cnt_d   = 8'd0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == PW_LAST) begin
                    if (!is_write_op(op_q)) begin
                        rdata_d = CART_DQ_I;
                    end
                    oen_d   = 1'b1;
                    wen_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HLD_LAST) begin
                    addr_d  = NIH;
                    dq_oe_d = 1'b0;
                    dq_o_d  = 8'h00;
                    cen_d   = 1'b1;
                    ssn_d   = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= 3'd0;
            addr_q      <= NIH;
            dq_o_q      <= 8'h00;
            dq_oe_q     <= 1'b0;
            cen_q       <= 1'b1;
            ssn_q       <= 1'b1;
            oen_q       <= 1'b1;
            wen_q       <= 1'b1;
            cart_rstn_q <= 1'b0;
            unlocked_q  <= 1'b0;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            so_q        <= 18'h0;
            bit_q       <= 5'd0;
            uidx_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            cen_q       <= cen_d;
            ssn_q       <= ssn_d;
            oen_q       <= oen_d;
            wen_q       <= wen_d;
            cart_rstn_q <= cart_rstn_d;
            unlocked_q  <= unlocked_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            so_q        <= so_d;
            bit_q       <= bit_d;
            uidx_q      <= uidx_d;
            armed_q     <= armed_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign unlocked   = unlocked_q;
    assign CART_RSTn  = cart_rstn_q;
    assign CART_ADDR  = addr_q;
    assign CART_DQ_O  = dq_o_q;
    assign CART_DQ_OE = dq_oe_q;
    assign CART_CEn   = cen_q;
    assign CART_SSn   = ssn_q;
    assign CART_OEn   = oen_q;
    assign CART_WEn   = wen_q;

endmodule
